data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the MEM stage. Serves the MemRead/MemWrite requests that the
//  main decoder raises for lw/sw. Each access has a fixed multi-cycle latency. stall_o
//  freezes the pipeline until the access completes. Word-addressed internal RAM; sits
//  between the EX/MEM pipeline register and the MEM/WB write-back mux.
// PARAMETERS
//  DATA_W   32   data word width in bits
//  ADDR_W   8    word-index bits; RAM depth = 2**ADDR_W words
//  LATENCY  4    access latency in cycles, legal range 1..15
// PORTS
//  clk_i      in   1       clock; all state updates on rising edge
//  rst_i      in   1       asynchronous, active-low reset
//  MemRead_i  in   1       load request (held stable by stalled pipeline)
//  MemWrite_i in   1       store request (held stable by stalled pipeline)
//  addr_i     in   32      byte address from ALU
//  data_i     in   DATA_W  store data
//  data_o     out  DATA_W  load data, valid in DONE cycle and held after
//  stall_o    out  1       1 = freeze PC/IF/ID/EX/MEM; combinational from state+request
//  done_o     out  1       1-cycle pulse: access completed this cycle
// BEHAVIOUR
//  Reset (rst_i=0, any time, async): state=IDLE, cnt=0, data_o=0, stall_o=0, done_o=0.
//   RAM contents are not reset. An in-flight store is dropped and never written.
//  req = MemRead_i | MemWrite_i. If both are 1, the access is a store; data_o is unchanged.
//  Index = addr_i[ADDR_W+1:2]. Bits [1:0] are ignored; bits above ADDR_W+1 are ignored (wrap).
//  FSM states:
//   IDLE: stall_o = req (combinational, same cycle the request arrives), done_o=0.
//     req=1: latch index, data_i, and is_write; cnt<=LATENCY-1; ->WAIT (LATENCY>1)
//       or ->DONE (LATENCY=1, access performed on this edge).
//     req=0: stay IDLE.
//   WAIT: stall_o=1, done_o=0. cnt>1: cnt<=cnt-1. cnt==1: perform access on this
//     edge, ->DONE.
//   DONE: stall_o=0, done_o=1. The pipeline advances at the end of this cycle.
//     req is ignored here (it is still the old request). ->IDLE unconditionally.
//  Access edge: store writes RAM[index]<=latched data. Load sets data_o<=RAM[index],
//   reading the pre-edge contents.
//  Latency: request seen in IDLE at cycle T -> stall_o=1 for cycles T..T+LATENCY-1.
//   done_o=1 and data_o valid at cycle T+LATENCY.
//  Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.
//   Minimum spacing is LATENCY+1 cycles.
//  Uses latched index/data only. Input changes during WAIT do not alter the access.
//  Cycles with no request: no RAM access, data_o holds its value.
// TESTING
//  1 Reset: rst_i=0 mid-WAIT of a store 0xDEADBEEF@0x10 -> stall_o=0, data_o=0 at once;
//    later lw 0x10 returns the prior value, not 0xDEADBEEF.
//  2 LATENCY=4: sw 0x12345678@0x20 at T -> stall_o=1 T..T+3, done_o=1 at T+4;
//    lw 0x20 at T+5 -> data_o=0x12345678 at T+9.
//  3 Back-to-back: sw 0xA@0x4 then lw 0x4 with no gap -> second request starts in the
//    cycle after DONE; no request lost or repeated; data_o=0xA.
//  4 Wrap/align: sw 0x55@0x403 (ADDR_W=8) -> lw 0x0 returns 0x55 (bits above 9 and
//    [1:0] ignored).
//  5 Both MemRead_i=MemWrite_i=1 with data 0x77@0x8 -> treated as store, data_o
//    unchanged; later lw 0x8 returns 0x77.
//  6 LATENCY=1: lw at T -> stall_o=1 only at T, done_o=1 at T+1; inputs changed
//    during WAIT (LATENCY=4) do not affect result.

Source files
------------

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: word-addressed RAM with a fixed access latency,
// stalling the pipeline from request acceptance until the DONE cycle.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic              isWrite;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } memReq_t;

  state_t            state, stateNxt;
  logic [3:0]        cnt;
  memReq_t           latReq, curReq, accReq;
  logic              req, accessEn;
  logic              unusedAddr;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign req        = MemRead_i | MemWrite_i;
  assign curReq     = {MemWrite_i, addr_i[ADDR_W+1:2], data_i};
  assign unusedAddr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

  always_comb begin
    stateNxt = state;
    stall_o  = 1'b0;
    done_o   = 1'b0;
    accessEn = 1'b0;
    accReq   = latReq;
    case (state)
      IDLE: begin
        stall_o = req;
        if (req) begin
          if (LATENCY == 1) begin
            // Single-cycle access uses the live request, nothing is latched yet.
            stateNxt = DONE;
            accessEn = 1'b1;
            accReq   = curReq;
          end else begin
            stateNxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        if (cnt == 4'd1) begin
          accessEn = 1'b1;
          stateNxt = DONE;
        end
      end
      DONE: begin
        done_o   = 1'b1;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
    // Held in reset: no stall and no RAM access, so an in-flight store is dropped.
    if (!rst_i) begin
      stall_o  = 1'b0;
      accessEn = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt    <= '0;
      latReq <= '0;
      data_o <= '0;
    end else begin
      if (state == IDLE && req) begin
        latReq <= curReq;
        cnt    <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (accessEn && !accReq.isWrite) data_o <= mem[accReq.idx];
    end
  end

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (accessEn && accReq.isWrite) mem[accReq.idx] <= accReq.data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=4 instance and one LATENCY=1 instance.
module tb_data_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, rd1, wr1;
  logic [31:0] addr, wdata, addr1, wdata1;
  logic [31:0] rdata, rdata1;
  logic        stall, done, stall1, done1;
  int          checks = 0;
  int          errors = 0;
  int          doneCnt = 0;
  int          d0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd), .MemWrite_i(wr), .addr_i(addr),
    .data_i(wdata), .data_o(rdata), .stall_o(stall), .done_o(done)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .MemRead_i(rd1), .MemWrite_i(wr1), .addr_i(addr1),
    .data_i(wdata1), .data_o(rdata1), .stall_o(stall1), .done_o(done1)
  );

  always @(negedge clk) if (done) doneCnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access to dut at the next negedge and follow it to its DONE cycle.
  task automatic acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit chkData, input bit perturb, input string tag);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
    chk({tag, " stall@T"}, {31'b0, stall}, 32'd1);
    chk({tag, " done@T"},  {31'b0, done},  32'd0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (perturb) begin addr = 32'h20; wdata = 32'hBAD; end
      #1;
      chk({tag, " stall@wait"}, {31'b0, stall}, 32'd1);
      chk({tag, " done@wait"},  {31'b0, done},  32'd0);
    end
    @(negedge clk);
    #1;
    chk({tag, " done@T+L"},  {31'b0, done},  32'd1);
    chk({tag, " stall@T+L"}, {31'b0, stall}, 32'd0);
    if (chkData) chk({tag, " data"}, rdata, exp);
  endtask

  task automatic acc1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input bit chkData, input string tag);
    @(negedge clk);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    #1;
    chk({tag, " stall@T"}, {31'b0, stall1}, 32'd1);
    chk({tag, " done@T"},  {31'b0, done1},  32'd0);
    @(negedge clk);
    #1;
    chk({tag, " done@T+1"},  {31'b0, done1},  32'd1);
    chk({tag, " stall@T+1"}, {31'b0, stall1}, 32'd0);
    if (chkData) chk({tag, " data"}, rdata1, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(negedge clk); #1;
    chk("rst stall",  {31'b0, stall},  32'd0);
    chk("rst done",   {31'b0, done},   32'd0);
    chk("rst data",   rdata,           32'd0);
    chk("rst1 stall", {31'b0, stall1}, 32'd0);
    chk("rst1 data",  rdata1,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Store then back-to-back load, nominal latency.
    acc(1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, "sw20");
    acc(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b1, 1'b0, "lw20");

    // No gap: exactly two completions, no lost/repeated request.
    d0 = doneCnt;
    acc(1'b0, 1'b1, 32'h4, 32'hA, 32'h0, 1'b0, 1'b0, "sw4");
    acc(1'b1, 1'b0, 32'h4, 32'h0, 32'hA, 1'b1, 1'b0, "lw4");
    chk("b2b done count", 32'(doneCnt - d0), 32'd2);

    // Index wrap and byte-offset ignore: 0x403 -> word 0.
    acc(1'b0, 1'b1, 32'h403, 32'h55, 32'h0, 1'b0, 1'b0, "sw403");
    acc(1'b1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b1, 1'b0, "lw0");

    // Read+write together is a store; data_o keeps the previous load.
    acc(1'b1, 1'b1, 32'h8, 32'h77, 32'h55, 1'b1, 1'b0, "rw8");
    acc(1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b1, 1'b0, "lw8");

    // Inputs disturbed during WAIT must not affect either access.
    acc(1'b0, 1'b1, 32'h40, 32'hCAFE, 32'h0, 1'b0, 1'b1, "sw40p");
    acc(1'b1, 1'b0, 32'h40, 32'h0, 32'hCAFE, 1'b1, 1'b1, "lw40p");
    idle(1);
    acc(1'b1, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b1, 1'b0, "lw20 intact");

    // Idle cycles: data_o holds.
    idle(3);
    #1;
    chk("idle hold data", rdata, 32'h12345678);
    chk("idle stall",     {31'b0, stall}, 32'd0);

    // Reset in the middle of a store drops it.
    acc(1'b0, 1'b1, 32'h10, 32'h11111111, 32'h0, 1'b0, 1'b0, "sw10");
    acc(1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b1, 1'b0, "lw10");
    @(negedge clk);
    rd = 1'b0; wr = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst stall", {31'b0, stall}, 32'd0);
    chk("midrst done",  {31'b0, done},  32'd0);
    chk("midrst data",  rdata,          32'd0);
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    acc(1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b1, 1'b0, "lw10 after rst");

    // Single-cycle latency instance.
    acc1(1'b0, 1'b1, 32'h30, 32'h99, 32'h0, 1'b0, "L1 sw30");
    acc1(1'b1, 1'b0, 32'h30, 32'h0, 32'h99, 1'b1, "L1 lw30");
    idle(2);
    #1;
    chk("L1 idle stall", {31'b0, stall1}, 32'd0);
    chk("L1 idle data",  rdata1,          32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
